fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the decode stage. It owns the PC register and issues in-order fetch requests to the instruction cache. Each request is steered by a BTB/direction-predictor lookup on the request PC. Returned instructions are buffered in a small in-order queue and presented to decode together with their PC, PC+4, predicted target, BTB way and predicted-taken bit. Redirects from execute flush the queue and discard stale in-flight responses.

---
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, BTB-steered requests, in-order refill queue.
// Define FETCH_BTB_EN to let BTB/direction hits steer the next fetch PC.
module fetch_stage #(
  parameter int ADDR_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_stall_d,
  output logic                   o_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_req_addr,
  input  logic                   i_req_ready,
  input  logic                   i_resp_valid,
  input  logic [INSTR_WIDTH-1:0] i_resp_instr,
  input  logic                   i_btb_hit,
  input  logic [ADDR_WIDTH-1:0]  i_btb_target,
  input  logic [1:0]             i_btb_way,
  input  logic                   i_bp_taken,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic [ADDR_WIDTH-1:0]  o_pc_target_pred,
  output logic [1:0]             o_btb_way,
  output logic                   o_branch_pred_taken
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [PW-1:0]         ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [CW:0]           occ_t;

  typedef struct packed {
    addr_t      pc;
    addr_t      pc4;
    addr_t      tgt;
    logic [1:0] way;
    logic       taken;
  } meta_t;

  localparam occ_t DEPTH_O = occ_t'(QUEUE_DEPTH);

  addr_t pc;
  addr_t pc4;
  addr_t pred_next;
  logic  pred_taken;
  logic [1:0] pred_way;

  meta_t                  meta_q  [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] filled;

  ptr_t head;
  ptr_t tail;
  ptr_t fptr;
  cnt_t alloc_cnt;
  cnt_t unfilled;
  cnt_t drop_cnt;

  occ_t occ;
  occ_t stale_total;
  cnt_t redir_drop;
  logic req_fire;
  logic resp_fill;
  logic resp_drop;
  logic head_live;
  logic pop;
  meta_t hm;

  assign pc4 = pc + addr_t'(4);

`ifdef FETCH_BTB_EN
  assign pred_taken = i_btb_hit & i_bp_taken;
  assign pred_way   = i_btb_way;
  assign pred_next  = pred_taken ? i_btb_target : pc4;
`else
  logic unused_btb;
  assign unused_btb = ^{i_btb_hit, i_btb_target, i_btb_way, i_bp_taken};
  assign pred_taken = 1'b0;
  assign pred_way   = 2'b00;
  assign pred_next  = pc4;
`endif

  // Stale responses still owed by the icache occupy slots too.
  assign occ = {1'b0, alloc_cnt} + {1'b0, drop_cnt};

  assign o_req_valid = ~i_arst & ~i_redirect & (occ < DEPTH_O);
  assign o_req_addr  = pc;
  assign req_fire    = o_req_valid & i_req_ready;

  assign resp_drop = i_resp_valid & (drop_cnt != '0);
  assign resp_fill = i_resp_valid & (drop_cnt == '0)
                   & (unfilled != '0);

  assign head_live = (alloc_cnt != '0) & filled[head];
  assign o_valid   = ~i_arst & head_live;
  assign pop       = o_valid & ~i_stall_d & ~i_redirect;

  // A response landing in the redirect cycle is itself stale.
  assign stale_total = {1'b0, drop_cnt} + {1'b0, unfilled};
  assign redir_drop  = cnt_t'(stale_total
                     - occ_t'(i_resp_valid && (stale_total != '0)));

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      pc        <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      alloc_cnt <= '0;
      unfilled  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (i_redirect) begin
      pc        <= i_redirect_pc;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      alloc_cnt <= '0;
      unfilled  <= '0;
      drop_cnt  <= redir_drop;
      filled    <= '0;
    end else begin
      if (req_fire) begin
        pc           <= pred_next;
        tail         <= tail + ptr_t'(1);
        filled[tail] <= 1'b0;
      end
      if (resp_fill) begin
        filled[fptr] <= 1'b1;
        fptr         <= fptr + ptr_t'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
      if (pop) begin
        head         <= head + ptr_t'(1);
        filled[head] <= 1'b0;
      end
      alloc_cnt <= alloc_cnt + cnt_t'(req_fire) - cnt_t'(pop);
      unfilled  <= unfilled + cnt_t'(req_fire) - cnt_t'(resp_fill);
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_fire) begin
      meta_q[tail].pc    <= pc;
      meta_q[tail].pc4   <= pc4;
      meta_q[tail].tgt   <= pred_next;
      meta_q[tail].way   <= pred_way;
      meta_q[tail].taken <= pred_taken;
    end
    if (resp_fill & ~i_redirect & ~i_arst) begin
      instr_q[fptr] <= i_resp_instr;
    end
  end

  assign hm = meta_q[head];

  assign o_instruction       = o_valid ? instr_q[head] : '0;
  assign o_pc                = o_valid ? hm.pc : '0;
  assign o_pc_plus4          = o_valid ? hm.pc4 : '0;
  assign o_pc_target_pred    = o_valid ? hm.tgt : '0;
  assign o_btb_way           = o_valid ? hm.way : 2'b00;
  assign o_branch_pred_taken = o_valid & hm.taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, corner sequences, random vs model.
// Model tracks the queue as a list of entries and the icache as a FIFO.
module tb_fetch_stage;

  localparam int D = 4;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_instr = '0;
  logic        btb_hit = 1'b0;
  logic [63:0] btb_target = '0;
  logic [1:0]  btb_way = '0;
  logic        bp_taken = 1'b0;
  logic        valid;
  logic [31:0] instruction;
  logic [63:0] pc, pc_plus4, pc_target_pred;
  logic [1:0]  way_o;
  logic        pred_taken;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_WIDTH(64), .INSTR_WIDTH(32),
    .QUEUE_DEPTH(D), .RESET_PC(RPC)
  ) dut (
    .i_clk(clk), .i_arst(arst),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_stall_d(stall),
    .o_req_valid(req_valid), .o_req_addr(req_addr),
    .i_req_ready(req_ready),
    .i_resp_valid(resp_valid), .i_resp_instr(resp_instr),
    .i_btb_hit(btb_hit), .i_btb_target(btb_target),
    .i_btb_way(btb_way), .i_bp_taken(bp_taken),
    .o_valid(valid), .o_instruction(instruction),
    .o_pc(pc), .o_pc_plus4(pc_plus4),
    .o_pc_target_pred(pc_target_pred),
    .o_btb_way(way_o), .o_branch_pred_taken(pred_taken)
  );

  typedef struct {
    logic [63:0] pc, pc4, tgt;
    logic [1:0]  way;
    logic        taken;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  ent_t        q[$];
  logic [31:0] pend[$];
  logic [63:0] m_pc = RPC;
  int          m_drop = 0;
  int          serial = 0;
  int          btb_mode = 0;
  int          checks = 0;
  int          errors = 0;

  logic        s_rv, s_v, s_taken;
  logic [63:0] s_addr, s_pc, s_pc4, s_tgt;
  logic [1:0]  s_way;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void lookup(input logic [63:0] a,
                                 output logic h, output logic t,
                                 output logic [63:0] tg,
                                 output logic [1:0] w);
    h = 1'b0; t = 1'b0; tg = '0; w = '0;
    if (btb_mode == 1) begin
      h = (a == 64'h100); t = h; tg = 64'h200; w = 2'd2;
    end else if (btb_mode == 2) begin
      h = a[4] ^ a[6]; t = a[3] | a[8];
      tg = (a ^ 64'h330) & ~64'h3; w = a[5:4];
    end
  endfunction

  task automatic tick(input bit rd, input logic [63:0] rpc,
                      input bit rdy, input bit rsp, input bit stl);
    logic h, t, eff;
    logic [63:0] tg;
    logic [1:0] w, wy;
    bit ex_rv, ex_v, fire, popd, rnow;
    ent_t e;
    int unf;
    bit found;
    logic [31:0] d;
    lookup(m_pc, h, t, tg, w);
    redirect = rd; redirect_pc = rpc; req_ready = rdy; stall = stl;
    btb_hit = h; bp_taken = t; btb_target = tg; btb_way = w;
    rnow = rsp && (pend.size() > 0);
    resp_valid = rnow;
    resp_instr = rnow ? pend[0] : $urandom;
    @(negedge clk);
    s_rv = req_valid; s_addr = req_addr; s_v = valid;
    s_pc = pc; s_pc4 = pc_plus4; s_tgt = pc_target_pred;
    s_way = way_o; s_taken = pred_taken;
    ex_rv = !rd && (q.size() + m_drop < D);
    ex_v = (q.size() > 0) && q[0].filled;
    if (ex_v) e = q[0];
    else begin
      e.pc = '0; e.pc4 = '0; e.tgt = '0; e.way = '0;
      e.taken = 1'b0; e.instr = '0; e.filled = 0;
    end
    chk("req_valid", 64'(req_valid), 64'(ex_rv));
    chk("req_addr", req_addr, m_pc);
    chk("valid", 64'(valid), 64'(ex_v));
    chk("instr", 64'(instruction), 64'(e.instr));
    chk("pc", pc, e.pc);
    chk("pc4", pc_plus4, e.pc4);
    chk("tgt", pc_target_pred, e.tgt);
    chk("way", 64'(way_o), 64'(e.way));
    chk("taken", 64'(pred_taken), 64'(e.taken));
    fire = ex_rv && rdy;
    popd = ex_v && !stl && !rd;
    @(posedge clk);
    #1;
    if (rd) begin
      unf = 0;
      foreach (q[i]) if (!q[i].filled) unf++;
      if (rnow) begin
        void'(pend.pop_front());
        if (m_drop > 0) m_drop--;
        else if (unf > 0) unf--;
      end
      m_drop += unf;
      q.delete();
      m_pc = rpc;
    end else begin
      if (rnow) begin
        d = pend.pop_front();
        if (m_drop > 0) m_drop--;
        else begin
          found = 0;
          foreach (q[i]) if (!found && !q[i].filled) begin
            q[i].instr = d; q[i].filled = 1; found = 1;
          end
          if (!found) begin
            errors++;
            $display("FAIL protocol response with nothing outstanding");
          end
        end
      end
      if (popd) void'(q.pop_front());
      if (fire) begin
`ifdef FETCH_BTB_EN
        eff = h & t; wy = w;
`else
        eff = 1'b0; wy = 2'b00;
`endif
        e.pc = m_pc; e.pc4 = m_pc + 64'd4;
        e.tgt = eff ? tg : m_pc + 64'd4;
        e.way = wy; e.taken = eff; e.instr = '0; e.filled = 0;
        q.push_back(e);
        pend.push_back({serial[15:0], m_pc[17:2]});
        serial++;
        m_pc = e.tgt;
      end
    end
  endtask

  task automatic do_reset(input int n);
    arst = 1'b1; redirect = 1'b0; resp_valid = 1'b0;
    req_ready = 1'b1; stall = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    arst = 1'b0;
    q.delete(); pend.delete();
    m_drop = 0; m_pc = RPC;
  endtask

  typedef struct {
    bit rdy, rsp, stl;
    bit erv;
    logic [63:0] eaddr;
    bit ev;
    logic [63:0] epc, epc4;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int nreq;
    bit seen;
    logic [63:0] exp_next, exp_tgt;
    logic [1:0] exp_way;
    bit exp_tk;

    tbl[0] = '{1, 0, 0, 1, 64'h8000_0000, 0, 64'h0, 64'h0};
    tbl[1] = '{1, 1, 0, 1, 64'h8000_0004, 0, 64'h0, 64'h0};
    tbl[2] = '{1, 1, 0, 1, 64'h8000_0008, 1, 64'h8000_0000, 64'h8000_0004};
    tbl[3] = '{1, 1, 0, 1, 64'h8000_000C, 1, 64'h8000_0004, 64'h8000_0008};
    tbl[4] = '{0, 1, 0, 1, 64'h8000_0010, 1, 64'h8000_0008, 64'h8000_000C};
    tbl[5] = '{0, 0, 0, 1, 64'h8000_0010, 1, 64'h8000_000C, 64'h8000_0010};
    tbl[6] = '{0, 0, 0, 1, 64'h8000_0010, 0, 64'h0, 64'h0};

    do_reset(2);

    for (int i = 0; i < 7; i++) begin
      tick(0, '0, tbl[i].rdy, tbl[i].rsp, tbl[i].stl);
      chk("tbl_req_valid", 64'(s_rv), 64'(tbl[i].erv));
      chk("tbl_req_addr", s_addr, tbl[i].eaddr);
      chk("tbl_valid", 64'(s_v), 64'(tbl[i].ev));
      chk("tbl_pc", s_pc, tbl[i].epc);
      chk("tbl_pc4", s_pc4, tbl[i].epc4);
    end

    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, '0, 1, 1, 1);
      if (s_rv) nreq++;
    end
    chk("full_reqs", 64'(nreq), 64'(D));
    chk("full_req_valid", 64'(s_rv), 64'd0);
    chk("stall_head", s_pc, 64'h8000_0010);
    for (int k = 0; k < 4; k++) begin
      tick(0, '0, 0, 0, 0);
      chk("drain_pc", s_pc, 64'h8000_0010 + 64'(4 * k));
    end
    tick(0, '0, 0, 0, 0);
    chk("drain_empty", 64'(s_v), 64'd0);

    btb_mode = 1;
`ifdef FETCH_BTB_EN
    exp_next = 64'h200; exp_tgt = 64'h200; exp_way = 2'd2; exp_tk = 1;
`else
    exp_next = 64'h104; exp_tgt = 64'h104; exp_way = 2'd0; exp_tk = 0;
`endif
    tick(1, 64'h100, 1, 0, 0);
    chk("redir_gate", 64'(s_rv), 64'd0);
    tick(0, '0, 1, 0, 0);
    chk("btb_req", s_addr, 64'h100);
    tick(0, '0, 0, 1, 0);
    chk("btb_next", s_addr, exp_next);
    tick(0, '0, 0, 0, 0);
    chk("btb_valid", 64'(s_v), 64'd1);
    chk("btb_pc", s_pc, 64'h100);
    chk("btb_tgt", s_tgt, exp_tgt);
    chk("btb_way", 64'(s_way), 64'(exp_way));
    chk("btb_taken", 64'(s_taken), 64'(exp_tk));
    btb_mode = 0;

    repeat (3) tick(0, '0, 1, 0, 0);
    tick(1, 64'h400, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, '0, 1, 1, 0);
      if (!seen && s_v) begin
        seen = 1;
        chk("redir_first_pc", s_pc, 64'h400);
      end
    end
    chk("redir_seen", 64'(seen), 64'd1);
    repeat (10) tick(0, '0, 0, 1, 0);

    tick(0, '0, 1, 0, 1);
    tick(0, '0, 1, 1, 1);
    tick(0, '0, 1, 0, 1);
    tick(1, 64'h600, 1, 1, 0);
    chk("rpop_valid", 64'(s_v), 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, '0, 1, 1, 0);
      if (i == 0) chk("rpop_flushed", 64'(s_v), 64'd0);
      if (!seen && s_v) begin
        seen = 1;
        chk("rpop_first_pc", s_pc, 64'h600);
      end
    end
    chk("rpop_seen", 64'(seen), 64'd1);
    repeat (10) tick(0, '0, 0, 1, 0);

    tick(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    tick(0, '0, 1, 0, 0);
    tick(0, '0, 0, 1, 0);
    chk("wrap_addr", s_addr, 64'h0);
    tick(0, '0, 0, 0, 0);
    chk("wrap_valid", 64'(s_v), 64'd1);
    chk("wrap_pc4", s_pc4, 64'h0);

    repeat (2) tick(0, '0, 1, 0, 0);
    do_reset(1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, '0, 1, 1, 0);
      if (!seen && s_v) begin
        seen = 1;
        chk("rst_first_pc", s_pc, RPC);
      end
    end
    chk("rst_seen", 64'(seen), 64'd1);

    btb_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else tick($urandom_range(0, 15) == 0,
                64'({$urandom, $urandom}) & ~64'h3,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
